booth_arbiter: RTL and testbench

- Round-robin scheduler that shares one booth_fsm multiplier between N_REQ requesters.
- Accepts operand pairs, sequences the multiplier load/done protocol, and holds operand m stable for the whole operation.
- Returns the signed product on a valid/ready response channel, tagged with the requester index.
- Sits between requester blocks and a single booth_fsm instance, which it drives through booth_if-equivalent signals.

---
 rtl/booth_arbiter_if.sv | 34 +++
 rtl/booth_arbiter.sv | 143 ++++++++++++++
 tb/tb_booth_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_arbiter_if.sv
// Bundle of requester, response and multiplier-side signals for booth_arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface booth_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int X     = 8,
  parameter int Y     = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*X-1:0] req_m;
  logic [N_REQ*Y-1:0] req_r;
  logic [N_REQ-1:0]   gnt;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [X+Y-1:0]     rsp_product;
  logic               rsp_err;
  logic               mul_load;
  logic [X-1:0]       mul_m;
  logic [Y-1:0]       mul_r;
  logic               mul_done;
  logic [X+Y-1:0]     mul_product;

  modport slave (
    input  req_valid, req_m, req_r, rsp_ready, mul_done, mul_product,
    output gnt, rsp_valid, rsp_id, rsp_product, rsp_err, mul_load, mul_m, mul_r
  );

  modport master (
    output req_valid, req_m, req_r, rsp_ready, mul_done, mul_product,
    input  gnt, rsp_valid, rsp_id, rsp_product, rsp_err, mul_load, mul_m, mul_r
  );
endinterface

// File: rtl/booth_arbiter.sv
// Round-robin scheduler sharing one Booth multiplier between N_REQ requesters,
// with a watchdog that turns a stuck multiplier into an error response.
module booth_arbiter #(
  parameter int N_REQ   = 4,
  parameter int X       = 8,
  parameter int Y       = 8,
  parameter int TIMEOUT = 2*Y+8
) (
  input  logic                 clk,
  input  logic                 reset,
  booth_arbiter_if.slave       bus,
  output logic [2:0]           dbg_state
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT+1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT-1);

  typedef enum logic [2:0] {
    SYNC, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [X-1:0]      m_q, m_d;
  logic [Y-1:0]      r_q, r_d;
  logic [X+Y-1:0]    prod_q, prod_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [N_REQ-1:0]  gnt_c;
  logic              found;
  logic [ID_W-1:0]   sel;

  function automatic logic [ID_W-1:0] wrap_idx(input int base, input int k);
    return ID_W'((base + k) % N_REQ);
  endfunction

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[wrap_idx(int'(rr_q), k)]) begin
        found = 1'b1;
        sel   = wrap_idx(int'(rr_q), k);
      end
    end
  end

  // Response channel: rsp_valid stays high with id/product/err frozen until
  // a cycle with rsp_ready high; that cycle is the transfer.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    m_d     = m_q;
    r_d     = r_q;
    prod_d  = prod_q;
    err_d   = err_q;
    wd_d    = wd_q;
    gnt_c   = '0;
    case (state_q)
      SYNC: begin
        if (bus.mul_done) state_d = IDLE;
      end
      IDLE: begin
        if (found) begin
          gnt_c[sel] = 1'b1;
          id_d       = sel;
          m_d        = bus.req_m[int'(sel)*X +: X];
          r_d        = bus.req_r[int'(sel)*Y +: Y];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wd_q == WD_LAST) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (!bus.mul_done) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.mul_done) begin
          prod_d  = bus.mul_product;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rr_d    = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SYNC;
      rr_q    <= '0;
      id_q    <= '0;
      m_q     <= '0;
      r_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      m_q     <= m_d;
      r_q     <= r_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.gnt         = gnt_c;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_product = prod_q;
  assign bus.rsp_err     = err_q;
  assign bus.mul_load    = (state_q == ISSUE);
  assign bus.mul_m       = m_q;
  assign bus.mul_r       = r_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_booth_arbiter.sv
// Bench for booth_arbiter: a behavioural Booth multiplier model plus
// scenario tasks compared against a round-robin/product reference model.
module tb_booth_arbiter;
  localparam int N   = 4;
  localparam int XW  = 8;
  localparam int YW  = 8;
  localparam int TO  = 2*YW+8;
  localparam int IDW = $clog2(N);
  localparam int PW  = XW+YW;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  logic       stuck;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         model_ptr = 0;

  booth_arbiter_if #(.N_REQ(N), .X(XW), .Y(YW)) bus ();

  booth_arbiter #(.N_REQ(N), .X(XW), .Y(YW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiplier model: one load cycle, Y+1 busy cycles ----------------
  logic          done_r = 1'b1;
  int            busy = 0;
  logic [XW-1:0] op_m = '0;
  logic [YW-1:0] op_r = '0;
  logic [PW-1:0] prod_r = '0;

  always @(posedge clk) begin
    if (!stuck) begin
      if (busy == 0) begin
        if (bus.mul_load) begin
          busy <= YW + 2;
          op_m <= bus.mul_m;
          op_r <= bus.mul_r;
        end
      end else begin
        busy <= busy - 1;
        if (busy == 1) begin
          done_r <= 1'b1;
          prod_r <= PW'(int'($signed(op_m)) * int'($signed(op_r)));
        end else begin
          done_r <= 1'b0;
        end
      end
    end
  end

  assign bus.mul_done    = stuck ? 1'b1 : done_r;
  assign bus.mul_product = prod_r;

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] ref_mul(input int m, input int r);
    int p;
    p = m * r;
    return p[PW-1:0];
  endfunction

  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input int id, input int m, input int r);
    bus.req_m[id*XW +: XW] = XW'(m);
    bus.req_r[id*YW +: YW] = YW'(r);
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic wait_gnt(output int t);
    t = -1;
    #1;
    for (int k = 0; k < 200 && t < 0; k++) begin
      if (bus.gnt != '0) t = cyc;
      else tick();
    end
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    #1;
    for (int k = 0; k < 200 && t < 0; k++) begin
      if (bus.rsp_valid) t = cyc;
      else tick();
    end
  endtask

  // Issue one request with rsp_ready high; returns in the response cycle.
  task automatic run_op(input int id, input int m, input int r,
                        output int tg, output logic [N-1:0] g, output int tr);
    bus.rsp_ready = 1'b1;
    issue_req(id, m, r);
    wait_gnt(tg);
    g = bus.gnt;
    tick();
    bus.req_valid[id] = 1'b0;
    wait_rsp(tr);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %h expected 0", bus.gnt); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id: got %h expected 0", bus.rsp_id); end
    n_checks++; if (bus.rsp_product !== '0) begin n_fail++; $display("FAIL reset_rsp_product: got %h expected 0", bus.rsp_product); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
    n_checks++; if (bus.mul_load !== 1'b0) begin n_fail++; $display("FAIL reset_mul_load: got %b expected 0", bus.mul_load); end
    n_checks++; if (bus.mul_m !== '0 || bus.mul_r !== '0) begin n_fail++; $display("FAIL reset_mul_operands: got %h/%h expected 0/0", bus.mul_m, bus.mul_r); end
    reset = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_single();
    int tg, tr;
    bus.rsp_ready = 1'b1;
    issue_req(0, 3, 5);
    wait_gnt(tg);
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b expected 0001", bus.gnt); end
    tick();
    bus.req_valid[0] = 1'b0;
    n_checks++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL single_gnt_pulse: got %b expected 0000", bus.gnt); end
    n_checks++; if (bus.mul_load !== 1'b1 || bus.mul_m !== 8'd3 || bus.mul_r !== 8'd5) begin
      n_fail++; $display("FAIL single_issue: got load=%b m=%h r=%h expected 1/03/05", bus.mul_load, bus.mul_m, bus.mul_r); end
    tick();
    n_checks++; if (bus.mul_load !== 1'b0) begin n_fail++; $display("FAIL single_load_pulse: got %b expected 0", bus.mul_load); end
    n_checks++; if (bus.mul_m !== 8'd3) begin n_fail++; $display("FAIL single_m_stable: got %h expected 03", bus.mul_m); end
    wait_rsp(tr);
    n_checks++; if (tr - tg !== YW + 5) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", tr - tg, YW + 5); end
    n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", bus.rsp_id); end
    n_checks++; if (bus.rsp_product !== ref_mul(3, 5)) begin n_fail++; $display("FAIL single_product: got %h expected %h", bus.rsp_product, ref_mul(3, 5)); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", bus.rsp_err); end
    model_ptr = 1;
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop: got %b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_signed();
    int tg, tr;
    logic [N-1:0] g;
    run_op(1, -3, 7, tg, g, tr);
    n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL signed_gnt: got %b expected 0010", g); end
    n_checks++; if (bus.rsp_product !== 16'hFFEB) begin n_fail++; $display("FAIL signed_neg3x7: got %h expected ffeb", bus.rsp_product); end
    n_checks++; if (bus.rsp_id !== 2'd1) begin n_fail++; $display("FAIL signed_id: got %0d expected 1", bus.rsp_id); end
    model_ptr = 2;
    tick();
    run_op(1, -128, -128, tg, g, tr);
    n_checks++; if (bus.rsp_product !== 16'h4000) begin n_fail++; $display("FAIL signed_min_sq: got %h expected 4000", bus.rsp_product); end
    n_checks++; if (tr - tg !== YW + 5) begin n_fail++; $display("FAIL signed_latency: got %0d expected %0d", tr - tg, YW + 5); end
    model_ptr = 2;
    tick();
  endtask

  task automatic test_round_robin();
    int tg, tr, e;
    logic [N-1:0] mask, eg;
    mask = 4'b1101;
    bus.rsp_ready = 1'b1;
    issue_req(0, 2, 2);
    issue_req(2, 2, 2);
    issue_req(3, 2, 2);
    for (int op = 0; op < 6; op++) begin
      e = pick(mask, model_ptr);
      eg = '0;
      eg[e] = 1'b1;
      wait_gnt(tg);
      n_checks++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", op, bus.gnt, eg); end
      tick();
      wait_rsp(tr);
      n_checks++; if (bus.rsp_id !== IDW'(e) || bus.rsp_product !== 16'd4) begin
        n_fail++; $display("FAIL rr_rsp[%0d]: got id=%0d prod=%h expected id=%0d prod=0004", op, bus.rsp_id, bus.rsp_product, e); end
      model_ptr = (e + 1) % N;
      if (op == 5) bus.req_valid = '0;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int tg, tr;
    bus.rsp_ready = 1'b0;
    issue_req(0, 5, -4);
    wait_gnt(tg);
    tick();
    bus.req_valid[0] = 1'b0;
    issue_req(1, -7, -9);
    wait_rsp(tr);
    for (int k = 0; k < 20; k++) begin
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_product !== 16'hFFEC || bus.rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d prod=%h err=%b expected 1/0/ffec/0", k, bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err); end
      n_checks++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL bp_no_gnt[%0d]: got %b expected 0000", k, bus.gnt); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    model_ptr = 1;
    tick();
    n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL bp_gnt_after_accept: got %b expected 0010", bus.gnt); end
    tick();
    bus.req_valid[1] = 1'b0;
    wait_rsp(tr);
    n_checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_product !== ref_mul(-7, -9)) begin
      n_fail++; $display("FAIL bp_second_rsp: got id=%0d prod=%h expected id=1 prod=%h", bus.rsp_id, bus.rsp_product, ref_mul(-7, -9)); end
    model_ptr = 2;
    tick();
  endtask

  task automatic test_timeout();
    int tg, tr;
    logic [N-1:0] g;
    stuck = 1'b1;
    run_op(3, 7, 9, tg, g, tr);
    n_checks++; if (tr - tg !== TO + 2) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", tr - tg, TO + 2); end
    n_checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_product !== '0 || bus.rsp_id !== 2'd3) begin
      n_fail++; $display("FAIL timeout_rsp: got err=%b prod=%h id=%0d expected 1/0000/3", bus.rsp_err, bus.rsp_product, bus.rsp_id); end
    model_ptr = 0;
    tick();
    stuck = 1'b0;
    run_op(2, -5, 11, tg, g, tr);
    n_checks++; if (tr - tg !== YW + 5) begin n_fail++; $display("FAIL timeout_recover_latency: got %0d expected %0d", tr - tg, YW + 5); end
    n_checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_product !== ref_mul(-5, 11)) begin
      n_fail++; $display("FAIL timeout_recover_rsp: got err=%b prod=%h expected 0/%h", bus.rsp_err, bus.rsp_product, ref_mul(-5, 11)); end
    model_ptr = 3;
    tick();
  endtask

  task automatic test_reset_mid_op();
    int tg, tr, td, tg2;
    bus.rsp_ready = 1'b1;
    issue_req(1, 9, 3);
    wait_gnt(tg);
    tick();
    bus.req_valid[1] = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_ptr = 0;
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_product !== '0 || bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_rsp: got v=%b id=%0d prod=%h err=%b expected all 0", bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err); end
    n_checks++; if (bus.mul_load !== 1'b0 || bus.mul_m !== '0 || bus.mul_r !== '0) begin
      n_fail++; $display("FAIL midrst_mul: got load=%b m=%h r=%h expected 0/00/00", bus.mul_load, bus.mul_m, bus.mul_r); end
    issue_req(0, 6, -2);
    #1;
    td = -1;
    for (int k = 0; k < 100 && td < 0; k++) begin
      if (bus.mul_done) td = cyc;
      else begin
        n_checks++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL midrst_sync_gnt: got %b expected 0000", bus.gnt); end
        tick();
      end
    end
    tick();
    wait_gnt(tg2);
    n_checks++; if (tg2 - td !== 1 || bus.gnt !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_first_gnt: got delay=%0d gnt=%b expected 1/0001", tg2 - td, bus.gnt); end
    tick();
    bus.req_valid[0] = 1'b0;
    wait_rsp(tr);
    n_checks++; if (bus.rsp_product !== 16'hFFF4 || bus.rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL midrst_next_rsp: got prod=%h id=%0d expected fff4/0", bus.rsp_product, bus.rsp_id); end
    model_ptr = 1;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]  held, add, keep, eg;
    int            om[N];
    int            orr[N];
    int            e, tg, tr, d, eid;
    logic [PW-1:0] exp_q[$];
    int            exp_id_q[$];
    held = '0;
    bus.rsp_ready = 1'b0;
    for (int op = 0; op < 16; op++) begin
      keep = N'($urandom_range(0, (1 << N) - 1));
      add  = N'($urandom_range(0, (1 << N) - 1));
      add[$urandom_range(0, N - 1)] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (add[i] && !held[i]) begin
          om[i]  = int'($urandom_range(0, (1 << XW) - 1)) - (1 << (XW - 1));
          orr[i] = int'($urandom_range(0, (1 << YW) - 1)) - (1 << (YW - 1));
          bus.req_m[i*XW +: XW] = XW'(om[i]);
          bus.req_r[i*YW +: YW] = YW'(orr[i]);
        end
      end
      held = (held & keep) | add;
      bus.req_valid = held;
      e = pick(held, model_ptr);
      eg = '0;
      eg[e] = 1'b1;
      wait_gnt(tg);
      n_checks++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL rand_gnt[%0d]: got %b expected %b", op, bus.gnt, eg); end
      exp_q.push_back(ref_mul(om[e], orr[e]));
      exp_id_q.push_back(e);
      tick();
      held[e] = 1'b0;
      bus.req_valid = held;
      wait_rsp(tr);
      d = int'($urandom_range(0, 3));
      repeat (d) tick();
      bus.rsp_ready = 1'b1;
      #1;
      eid = exp_id_q.pop_front();
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(eid)) begin
        n_fail++; $display("FAIL rand_id[%0d]: got v=%b id=%0d expected 1/%0d", op, bus.rsp_valid, bus.rsp_id, eid); end
      n_checks++; if (bus.rsp_product !== exp_q[0] || bus.rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL rand_product[%0d]: got %h err=%b expected %h err=0", op, bus.rsp_product, bus.rsp_err, exp_q[0]); end
      void'(exp_q.pop_front());
      model_ptr = (e + 1) % N;
      tick();
      bus.rsp_ready = 1'b0;
    end
    bus.req_valid = '0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    stuck = 1'b0;
    bus.req_valid = '0;
    bus.req_m = '0;
    bus.req_r = '0;
    bus.rsp_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_signed();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
